// File: rtl/tick_timer_ctrl_pkg.sv
// Shared types and constants for the four-channel tick timer controller.
// Channel state encodings, mode encodings and channel-index helpers.
package tick_timer_ctrl_pkg;

    localparam int NumCh = 4;
    localparam int ChW   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Round-robin successor; the 2-bit width gives the 3->0 wrap for free.
    function automatic logic [ChW-1:0] next_ch(input logic [ChW-1:0] ch);
        return ch + ChW'(1);
    endfunction

endpackage

// File: rtl/tick_timer_ctrl_if.sv
// Control, configuration and event-port bundle of the tick timer controller,
// plus read-only debug views of the channel FSMs and counters.
interface tick_timer_ctrl_if #(
    parameter int Width  = 8,
    parameter int PrescW = 4
);
    import tick_timer_ctrl_pkg::*;

    logic [PrescW-1:0]           presc_div;
    logic                        cfg_we;
    logic [ChW-1:0]              cfg_ch;
    logic [Width-1:0]            cfg_period;
    logic                        cfg_mode;
    logic [NumCh-1:0]            start;
    logic [NumCh-1:0]            stop;
    logic [NumCh-1:0]            busy;
    // Event port: evt_valid/evt_ch are held until a cycle with evt_valid && evt_ready;
    // that cycle is the transfer. evt_ready while evt_valid is low has no effect.
    logic                        evt_valid;
    logic [ChW-1:0]              evt_ch;
    logic                        evt_ready;
    logic                        ovf;
    state_t [NumCh-1:0]          ch_state;
    logic [NumCh-1:0][Width-1:0] ch_cnt;
    logic [PrescW-1:0]           presc_cnt;

    modport master (
        output presc_div, cfg_we, cfg_ch, cfg_period, cfg_mode, start, stop, evt_ready,
        input  busy, evt_valid, evt_ch, ovf, ch_state, ch_cnt, presc_cnt
    );

    modport slave (
        input  presc_div, cfg_we, cfg_ch, cfg_period, cfg_mode, start, stop, evt_ready,
        output busy, evt_valid, evt_ch, ovf, ch_state, ch_cnt, presc_cnt
    );

endinterface

// File: rtl/tick_timer_ctrl_rr_arbiter4.sv
// Combinational four-way round-robin pick: first requester at or after ptr,
// wrapping 3->0.
module rr_arbiter4
    import tick_timer_ctrl_pkg::*;
(
    input  logic [NumCh-1:0] req,
    input  logic [ChW-1:0]   ptr,
    output logic             gnt_valid,
    output logic [ChW-1:0]   gnt_idx
);

    logic [ChW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = NumCh - 1; k >= 0; k--) begin
            idx = ptr + ChW'(k);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/tick_timer_ctrl.sv
// Four-channel interval timer: shared prescaler, per-channel down-counters,
// pending flags drained one at a time through a round-robin event port.
module tick_timer_ctrl
    import tick_timer_ctrl_pkg::*;
#(
    parameter int Width  = 8,
    parameter int PrescW = 4
) (
    input logic               clk,
    input logic               rst,
    tick_timer_ctrl_if.slave  bus
);

    logic [PrescW-1:0]           presc_cnt;
    logic                        base_tick;
    state_t [NumCh-1:0]          state;
    logic [NumCh-1:0][Width-1:0] cnt;
    logic [NumCh-1:0][Width-1:0] period;
    logic [NumCh-1:0]            mode;
    logic [NumCh-1:0]            busy_q;
    logic [NumCh-1:0]            expire;
    logic [NumCh-1:0]            pending;
    logic [NumCh-1:0]            ack;
    logic                        evt_valid_q;
    logic [ChW-1:0]              evt_ch_q;
    logic [ChW-1:0]              ptr;
    logic                        ovf_q;
    logic                        gnt_valid;
    logic [ChW-1:0]              gnt_idx;

    // A count above a freshly lowered presc_div runs up to all-ones and wraps without a tick.
    assign base_tick = (presc_cnt == bus.presc_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (base_tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PrescW'(1);
        end
    end

    // start and stop both pre-empt an expiry on the same cycle.
    always_comb begin
        expire = '0;
        for (int i = 0; i < NumCh; i++) begin
            expire[i] = (state[i] == ST_RUN) && base_tick && (cnt[i] == '0)
                        && !bus.start[i] && !bus.stop[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumCh; i++) begin
                state[i] <= ST_IDLE;
            end
            cnt    <= '0;
            period <= '0;
            mode   <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (bus.cfg_we && (bus.cfg_ch == ChW'(i))) begin
                    period[i] <= bus.cfg_period;
                    mode[i]   <= bus.cfg_mode;
                end
                if (bus.stop[i]) begin
                    state[i]  <= ST_IDLE;
                    busy_q[i] <= 1'b0;
                end else if (bus.start[i]) begin
                    state[i]  <= ST_RUN;
                    busy_q[i] <= 1'b1;
                    cnt[i]    <= period[i];
                end else if ((state[i] == ST_RUN) && base_tick) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - Width'(1);
                    end else if (mode[i] == MODE_PERIODIC) begin
                        cnt[i] <= period[i];
                    end else begin
                        state[i]  <= ST_IDLE;
                        busy_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        ack = '0;
        if (evt_valid_q && bus.evt_ready) begin
            ack[evt_ch_q] = 1'b1;
        end
    end

    rr_arbiter4 u_arb (
        .req       (pending),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // A re-expiry on the acknowledge cycle keeps the flag set and is not an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            ovf_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            ptr         <= '0;
        end else begin
            pending <= expire | (pending & ~ack);
            ovf_q   <= |(expire & pending & ~ack);
            if (evt_valid_q) begin
                if (bus.evt_ready) begin
                    evt_valid_q <= 1'b0;
                    ptr         <= next_ch(evt_ch_q);
                end
            end else if (gnt_valid) begin
                evt_valid_q <= 1'b1;
                evt_ch_q    <= gnt_idx;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_ch    = evt_ch_q;
    assign bus.ovf       = ovf_q;
    assign bus.ch_state  = state;
    assign bus.ch_cnt    = cnt;
    assign bus.presc_cnt = presc_cnt;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl: per-cycle vector tables plus hand-written
// sequences for reset, reconfiguration and prescaler-change corner cases.
module tb_tick_timer_ctrl;
    import tick_timer_ctrl_pkg::*;

    logic clk;
    logic rst;

    tick_timer_ctrl_if #(.Width(8), .PrescW(4)) bus ();

    tick_timer_ctrl #(.Width(8), .PrescW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] start;
        logic [3:0] stop;
        logic       ready;
        logic [3:0] exp_busy;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] st, input logic [3:0] sp, input logic rdy,
                       input logic [3:0] b, input logic v, input logic [1:0] c, input logic o);
        vec_t x;
        x.start = st; x.stop = sp; x.ready = rdy;
        x.exp_busy = b; x.exp_valid = v; x.exp_ch = c; x.exp_ovf = o;
        for (int k = 0; k < n; k++) tbl.push_back(x);
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.start     = tbl[i].start;
            bus.stop      = tbl[i].stop;
            bus.evt_ready = tbl[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy), 32'(tbl[i].exp_busy));
            check($sformatf("%s[%0d].evt_valid", tag, i), 32'(bus.evt_valid), 32'(tbl[i].exp_valid));
            check($sformatf("%s[%0d].ovf", tag, i), 32'(bus.ovf), 32'(tbl[i].exp_ovf));
            if (tbl[i].exp_valid)
                check($sformatf("%s[%0d].evt_ch", tag, i), 32'(bus.evt_ch), 32'(tbl[i].exp_ch));
        end
        bus.start = '0;
        bus.stop  = '0;
        tbl.delete();
    endtask

    task automatic do_reset(input logic [3:0] pd);
        bus.presc_div  = pd;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_period = '0;
        bus.cfg_mode   = 1'b0;
        bus.start      = '0;
        bus.stop       = '0;
        bus.evt_ready  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] per, input logic md);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = ch;
        bus.cfg_period = per;
        bus.cfg_mode   = md;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;

        // Reset values.
        do_reset(4'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.evt_valid", 32'(bus.evt_valid), 32'd0);
        check("rst.evt_ch", 32'(bus.evt_ch), 32'd0);
        check("rst.ovf", 32'(bus.ovf), 32'd0);

        // Reset mid-run clears everything asynchronously.
        cfg_write(2'd0, 8'd5, MODE_PERIODIC);
        bus.start = 4'b0001;
        @(posedge clk);
        #1 bus.start = '0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst.busy_before", 32'(bus.busy), 32'h1);
        check("midrst.cnt_before", 32'(bus.ch_cnt[0]), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.evt_valid", 32'(bus.evt_valid), 32'd0);
        check("midrst.ovf", 32'(bus.ovf), 32'd0);
        check("midrst.cnt", 32'(bus.ch_cnt), 32'd0);
        check("midrst.state", 32'(bus.ch_state), 32'd0);
        check("midrst.presc", 32'(bus.presc_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("midrst.no_evt", 32'({bus.evt_valid, bus.busy}), 32'd0);
        end

        // presc_div=0, ch1 periodic period 3, ready held high.
        do_reset(4'd0);
        cfg_write(2'd1, 8'd3, MODE_PERIODIC);
        add(1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
        add(4, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(3, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(3, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        run_tbl("periodic_ch1");

        // presc_div=2, ch2 one-shot period 1: single event, then quiet.
        do_reset(4'd2);
        cfg_write(2'd2, 8'd1, MODE_ONESHOT);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
        add(5, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
        add(50, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        run_tbl("oneshot_ch2");

        // All channels period 0: round-robin order with overflow.
        do_reset(4'd0);
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 8'd0, MODE_PERIODIC);
        add(1, 4'b1111, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 2'd1, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 2'd2, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 2'd3, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b1);
        run_tbl("all_rr");

        // ch3 period 2 with back-pressure: held event, ovf on each lost expiry.
        do_reset(4'd0);
        cfg_write(2'd3, 8'd2, MODE_PERIODIC);
        add(1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0);
        add(3, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0);
        add(2, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
        add(2, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0);
        add(2, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
        run_tbl("backpressure_ch3");

        // start&stop together stays idle; stop on the expiry cycle drops the event.
        do_reset(4'd0);
        cfg_write(2'd0, 8'd2, MODE_PERIODIC);
        add(1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
        add(2, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
        add(1, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(3, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        run_tbl("stop_ch0");

        // Period rewrite while running: current interval kept, next one is 8 ticks.
        bus.evt_ready = 1'b1;
        bus.start = 4'b0001;
        @(posedge clk);
        #1 bus.start = '0;
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'd0;
        bus.cfg_period = 8'd7;
        bus.cfg_mode   = MODE_PERIODIC;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("recfg.reload_cnt", 32'(bus.ch_cnt[0]), 32'd7);
        check("recfg.valid_t3", 32'(bus.evt_valid), 32'd0);
        @(posedge clk);
        #1;
        check("recfg.valid_t4", 32'(bus.evt_valid), 32'd1);
        check("recfg.ch_t4", 32'(bus.evt_ch), 32'd0);
        for (int k = 5; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("recfg.valid_t%0d", k), 32'(bus.evt_valid), 32'(k == 12));
        end

        // Lowering presc_div below the running count: wrap through 15 with no tick.
        do_reset(4'd7);
        cfg_write(2'd0, 8'd0, MODE_ONESHOT);
        repeat (4) @(posedge clk);
        #1;
        check("presc.cnt_before", 32'(bus.presc_cnt), 32'd5);
        bus.presc_div = 4'd2;
        bus.start     = 4'b0001;
        @(posedge clk);
        #1 bus.start = '0;
        check("presc.cnt_e5", 32'(bus.presc_cnt), 32'd6);
        check("presc.busy_e5", 32'(bus.busy), 32'h1);
        for (int k = 6; k <= 18; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("presc.cnt_e%0d", k), 32'(bus.presc_cnt), (k == 18) ? 32'd0 : 32'((k + 1) % 16));
            check($sformatf("presc.busy_e%0d", k), 32'(bus.busy), (k < 18) ? 32'h1 : 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
